// File: rtl/alu_sequencer.sv
// alu_sequencer
// Steps through a short instruction program for the 4-bit Decode_And_Execute
// ALU. The host fills the register file and the program buffer while idle and
// then pulses start. Each instruction runs in two cycles: FETCH latches the
// operands and select, and EXEC writes the ALU result back to the register file.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   wr_en/addr/data     host register write, honoured only while idle
//   load_valid/instr    program load offer {sel, rd_idx, rs_idx, rt_idx}
//   load_ready          buffer accepts (idle, not full, start low)
//   start               run the loaded program
//   busy, done, pc      run status, end-of-program pulse, instruction index
//   alu_rs/rt/sel       registered ALU operands and select
//   alu_rd              combinational ALU result
//   dbg_addr, dbg_data  zero-latency register file read port
module alu_sequencer #(
  parameter int PROG_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       load_valid,
  input  logic [8:0] load_instr,
  output logic       load_ready,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [2:0] pc,
  output logic [3:0] alu_rs,
  output logic [3:0] alu_rt,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_rd,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
);

  localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam int CW = $clog2(PROG_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  state_t        state;
  logic [8:0]    prog [PROG_DEPTH];
  logic [3:0]    rf [4];
  logic [CW-1:0] count;
  logic [8:0]    instr;
  logic          load_fire;
  logic          last;

  assign instr      = prog[pc[AW-1:0]];
  assign load_ready = (state == IDLE) && (count < CW'(PROG_DEPTH)) && !start;
  assign load_fire  = load_valid && load_ready;
  assign last       = (CW'(pc) == (count - CW'(1)));
  assign busy       = (state != IDLE);
  assign dbg_data   = rf[dbg_addr];

  // Program buffer needs no reset; stale entries are never executed because
  // count bounds the run.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      prog[count[AW-1:0]] <= load_instr;
    end
  end

  // Sequencer FSM. The register file lives here because both the host write
  // (idle) and the EXEC write-back target it, never in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      pc      <= '0;
      done    <= 1'b0;
      alu_rs  <= '0;
      alu_rt  <= '0;
      alu_sel <= '0;
      for (int i = 0; i < 4; i++) begin
        rf[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            rf[wr_addr] <= wr_data;
          end
          if (load_fire) begin
            count <= count + CW'(1);
          end
          if (start && (count != '0)) begin
            pc    <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          alu_rs  <= rf[instr[3:2]];
          alu_rt  <= rf[instr[1:0]];
          alu_sel <= instr[8:6];
          state   <= EXEC;
        end
        EXEC: begin
          rf[instr[5:4]] <= alu_rd;
          if (last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            pc    <= pc + 3'd1;
            state <= FETCH;
          end
        end
        DONE: begin
          count <= '0;
          pc    <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Program sequencer for the 4-bit Decode_And_Execute ALU. The host writes operand registers, loads a short instruction program through a valid/ready port, and pulses start. The block then steps through the program, drives the ALU operands and select, and writes each result back into a 4-entry × 4-bit register file. It sits between the FPGA switch/button front end and the ALU; the result display reads the register file through a debug port.

## Interface
- PROG_DEPTH, 8, instruction buffer entries; power of two, ≤ 8.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  host register write; honoured only in IDLE.
- wr_addr  in  2  host write register index.
- wr_data  in  4  host write data.
- load_valid  in  1  instruction offered.
- load_instr  in  9  {sel[2:0], rd_idx[1:0], rs_idx[1:0], rt_idx[1:0]}.
- load_ready  out  1  buffer accepts; equals IDLE & count<PROG_DEPTH & !start.
- start  in  1  run the loaded program.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at program end.
- pc  out  3  index of the instruction in flight.
- alu_rs, alu_rt  out  4  registered ALU operands.
- alu_sel  out  3  registered ALU select.
- alu_rd  in  4  combinational ALU result.
- dbg_addr  in  2  register file read index.
- dbg_data  out  4  combinational read of reg[dbg_addr].

## Operation
- **Storage**
  - Register file reg[0..3], 4 bits each.
  - Program buffer prog[0..PROG_DEPTH-1].
  - count: 0..PROG_DEPTH, stored one bit wider than log2(PROG_DEPTH).
- **Load**
  - A transfer happens when load_valid & load_ready at a clock edge.
  - The transfer writes prog[count] and increments count.
  - When count = PROG_DEPTH, load_ready = 0 and offers are not taken (no overwrite).
- **Host write**
  - In IDLE, wr_en writes reg[wr_addr] at the edge.
  - Outside IDLE, wr_en is ignored.
- **States**
  - IDLE
    - start & count>0 → FETCH, with pc=0.
    - start & count=0 is ignored; the block stays in IDLE.
  - FETCH
    - Latch alu_rs=reg[rs_idx], alu_rt=reg[rt_idx], alu_sel=sel of prog[pc].
    - → EXEC.
  - EXEC
    - Write reg[rd_idx] ← alu_rd at the edge.
    - If pc = count-1 → DONE; otherwise pc+1 → FETCH.
  - DONE
    - done=1 for this cycle.
    - count ← 0 (program consumed); pc ← 0.
    - → IDLE.
- **ALU interface**
  - The sequencer does not interpret sel.
  - All arithmetic is inside the ALU and is mod 16.
- **Dependencies**
  - The next FETCH reads the register file after the EXEC write, so back-to-back dependent instructions see updated values.
  - No forwarding is needed.
- **Simultaneous events in IDLE**
  - wr_en with start: the write lands, and the first FETCH sees it.
  - load_valid with start: start wins; load_ready=0, so the instruction is not taken.
- **Reset (any time, including mid-run)**
  - State=IDLE, count=0, pc=0.
  - All reg=0, alu_rs=alu_rt=0, alu_sel=0.
  - done=0, busy=0.
  - load_ready=1 while start is low.
  - The program buffer contents are don't-care.

## Timing
- Each instruction takes 2 cycles (FETCH, EXEC).
- For an N-instruction program, with start sampled at edge 0:
  - busy rises after edge 0.
  - The write-back for instruction k happens at edge 2k+2.
  - done is high during cycle 2N+1 (between edges 2N and 2N+1).
  - busy falls after edge 2N+1.
- alu_* outputs change only at FETCH edges and hold their values otherwise.
- dbg_data has zero latency; a write-back is visible the cycle after its edge.

## Test plan
- **Reset**
  - Stimulus: apply rst mid-simulation.
  - Required: busy=done=0, alu_*=0, pc=0, dbg_data=0 for all 4 indices, load_ready=1.
- **Basic run**
  - Stimulus: write R0=5, R1=3; load ADD(sel 1) R2=R0+R1 and SUB(sel 0) R3=R0-R1; start, with the bench wiring Decode_And_Execute to alu_*.
  - Required: R2=8 after edge 2, R3=2 after edge 4, done during cycle 5, busy low after edge 5, count=0.
- **Wrap-around and compare**
  - Stimulus: R0=R1=9; ADD R2=R0+R1; CMP_EQ(sel 7) R3=R0,R1.
  - Required: R2=2, R3=1.
- **Full buffer and dependencies**
  - Stimulus: R0=1; load 8× ADD R0=R0+R0; offer a 9th instruction.
  - Required: load_ready=0 after the 8th transfer and the 9th is not taken; after start, R0=8 after the 3rd write-back and R0=0 at done.
- **Reset mid-run**
  - Stimulus: assert rst during the EXEC of instruction 1 of a 4-instruction program.
  - Required: busy drops immediately, no done pulse, all registers 0, count=0.
- **Ignored inputs**
  - Stimulus: start with count=0; separately, wr_en with R1=7 while busy.
  - Required: start with count=0 leaves busy at 0; the write while busy leaves R1 unchanged.
